// File: rtl/dsn_slave.sv
// ---------------------------------------------------------------------------
// dsn_slave -- 1-Wire (Dallas serial number) slave responder.
//
// Answers a bus reset with a presence pulse, then receives one command byte.
// For Read ROM (8'h33) it returns 64 ROM bits, LSB first: the family code,
// then the 48-bit serial number, then the CRC byte. For any other command it
// goes quiet until the next bus reset.
//
// Build option:
//   DSN_SLAVE_CRC_EN  defined   -> the ROM CRC byte is the Dallas CRC-8
//                                  (x^8+x^5+x^4+1, init 0) of rom_id, computed
//                                  here; crc_in is ignored.
//                     undefined -> the ROM CRC byte is crc_in, unchanged.
//
// Ports:
//   clock         in   40 MHz clock, single domain
//   global_reset  in   synchronous active-high reset
//   dsn_io        io   1-Wire line, open drain (driven 0 or z), external pullup
//   rom_id        in   [7:0] family code, [55:8] serial number
//   crc_in        in   ROM CRC byte (used only without DSN_SLAVE_CRC_EN)
//   busy          out  high in every state except idle
//   cmd_byte      out  last complete command byte received
//   rom_sent      out  one-clock pulse after the 64th ROM bit slot
// ---------------------------------------------------------------------------
module dsn_slave #(
  parameter int MXCNT      = 16,
  parameter int CNT_RST    = 19200,
  parameter int CNT_SAMPLE = 1200,
  parameter int CNT_PWAIT  = 1200,
  parameter int CNT_PRES   = 4800,
  parameter int CNT_RD0    = 1200
) (
  input  logic        clock,
  input  logic        global_reset,
  inout  wire         dsn_io,
  input  logic [55:0] rom_id,
  input  logic [7:0]  crc_in,
  output logic        busy,
  output logic [7:0]  cmd_byte,
  output logic        rom_sent
);

  localparam logic [MXCNT-1:0] C_RST      = MXCNT'(CNT_RST);
  localparam logic [MXCNT-1:0] C_SAMPLE   = MXCNT'(CNT_SAMPLE);
  localparam logic [MXCNT-1:0] C_PWAIT_M1 = MXCNT'(CNT_PWAIT - 1);
  localparam logic [MXCNT-1:0] C_PRES_M1  = MXCNT'(CNT_PRES - 1);
  localparam logic [MXCNT-1:0] C_RD0      = MXCNT'(CNT_RD0);
  localparam logic [MXCNT-1:0] C_RD0_M1   = MXCNT'(CNT_RD0 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PWAIT  = 3'd1,
    S_PDRIVE = 3'd2,
    S_CMD    = 3'd3,
    S_ROM    = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e           state_q;
  logic             sync1_q;
  logic             sync_q;
  logic             prev_q;
  logic [MXCNT-1:0] low_cnt_q;
  logic [MXCNT-1:0] cnt_q;
  logic             slot_act_q;
  logic [5:0]       idx_q;
  logic [6:0]       sh_q;
  logic [7:0]       cmd_byte_q;
  logic             rom_sent_q;
  logic             busy_q;
  logic             drive_q;

  logic             fall_d;
  logic             line_rst_d;
  logic             slot_go_d;
  logic [7:0]       shift_d;
  logic [7:0]       rom_crc;
  logic [63:0]      rom_bits;

  // Open-drain output: only ever pull low or float.
  assign dsn_io   = drive_q ? 1'b0 : 1'bz;
  assign busy     = busy_q;
  assign cmd_byte = cmd_byte_q;
  assign rom_sent = rom_sent_q;

  // -------------------------------------------------------------------------
  // ROM CRC byte
  // -------------------------------------------------------------------------
`ifdef DSN_SLAVE_CRC_EN
  logic crc_in_unused;
  assign crc_in_unused = ^crc_in;

  // Bit-serial Dallas CRC-8 unrolled over all 56 ROM bits, LSB first.
  always_comb begin
    logic fb;
    fb      = 1'b0;
    rom_crc = '0;
    for (int unsigned i = 0; i < 56; i++) begin
      fb      = rom_crc[0] ^ rom_id[i];
      rom_crc = {1'b0, rom_crc[7:1]};
      if (fb) rom_crc = rom_crc ^ 8'h8C;
    end
  end
`else
  assign rom_crc = crc_in;
`endif

  assign rom_bits = {rom_crc, rom_id};

  // -------------------------------------------------------------------------
  // Line synchronizer, edge detect and low-time measurement
  // -------------------------------------------------------------------------
  // Reset the synchronizer to "line high" so leaving reset never looks like
  // a falling edge.
  always_ff @(posedge clock) begin
    if (global_reset) begin
      sync1_q <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= dsn_io;
      sync_q  <= sync1_q;
      prev_q  <= sync_q;
    end
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      low_cnt_q <= '0;
    end else if (sync_q) begin
      low_cnt_q <= '0;
    end else if (low_cnt_q != '1) begin
      low_cnt_q <= low_cnt_q + MXCNT'(1);
    end
  end

  assign fall_d     = prev_q & ~sync_q;
  // On the rising edge low_cnt_q still holds the full low time; it clears
  // on the following clock.
  assign line_rst_d = sync_q & ~prev_q & (low_cnt_q >= C_RST);
  // Edges caused by our own pull-down never open a slot.
  assign slot_go_d  = fall_d & ~drive_q & ~slot_act_q;
  assign shift_d    = {sync_q, sh_q};

  // -------------------------------------------------------------------------
  // Protocol FSM. cnt_q is shared: presence-wait timer, presence width, and
  // the per-slot timer in cmd / rom_tx.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (global_reset) begin
      state_q    <= S_IDLE;
      drive_q    <= 1'b0;
      cnt_q      <= '0;
      slot_act_q <= 1'b0;
      idx_q      <= '0;
      sh_q       <= '0;
      cmd_byte_q <= '0;
      rom_sent_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rom_sent_q <= 1'b0;
      if (line_rst_d) begin
        // A bus reset aborts whatever is in progress.
        state_q    <= S_PWAIT;
        busy_q     <= 1'b1;
        drive_q    <= 1'b0;
        cnt_q      <= '0;
        slot_act_q <= 1'b0;
        idx_q      <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            drive_q    <= 1'b0;
            slot_act_q <= 1'b0;
          end

          S_PWAIT: begin
            if (cnt_q == C_PWAIT_M1) begin
              state_q <= S_PDRIVE;
              drive_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + MXCNT'(1);
            end
          end

          S_PDRIVE: begin
            if (cnt_q == C_PRES_M1) begin
              state_q    <= S_CMD;
              drive_q    <= 1'b0;
              cnt_q      <= '0;
              idx_q      <= '0;
              slot_act_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + MXCNT'(1);
            end
          end

          S_CMD: begin
            if (slot_act_q) begin
              if (cnt_q == C_SAMPLE) begin
                slot_act_q <= 1'b0;
                sh_q       <= shift_d[7:1];
                if (idx_q == 6'd7) begin
                  cmd_byte_q <= shift_d;
                  idx_q      <= '0;
                  state_q    <= (shift_d == 8'h33) ? S_ROM : S_DONE;
                end else begin
                  idx_q <= idx_q + 6'd1;
                end
              end else begin
                cnt_q <= cnt_q + MXCNT'(1);
              end
            end else if (slot_go_d) begin
              slot_act_q <= 1'b1;
              cnt_q      <= '0;
            end
          end

          S_ROM: begin
            if (slot_act_q) begin
              // Hold a 0 bit for exactly CNT_RD0 clocks, then wait for the
              // line to float high before moving to the next bit.
              if (cnt_q != C_RD0) begin
                cnt_q <= cnt_q + MXCNT'(1);
                if (cnt_q == C_RD0_M1) drive_q <= 1'b0;
              end else if (sync_q) begin
                slot_act_q <= 1'b0;
                if (idx_q == 6'd63) begin
                  rom_sent_q <= 1'b1;
                  state_q    <= S_DONE;
                  idx_q      <= '0;
                end else begin
                  idx_q <= idx_q + 6'd1;
                end
              end
            end else if (slot_go_d) begin
              slot_act_q <= 1'b1;
              cnt_q      <= '0;
              drive_q    <= ~rom_bits[idx_q];
            end
          end

          S_DONE: begin
            drive_q    <= 1'b0;
            slot_act_q <= 1'b0;
          end

          default: begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            drive_q    <= 1'b0;
            slot_act_q <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsn_slave.sv
// ---------------------------------------------------------------------------
// tb_dsn_slave -- directed self-checking bench for dsn_slave.
// Timing parameters are scaled down so a full Read ROM sequence stays short:
// reset low 600 clocks (> 480), write-1 low 4, write-0 low 100, read slot
// low 2 with the master sample 8 clocks after its falling edge.
// ---------------------------------------------------------------------------
module tb_dsn_slave;

  localparam int PWAIT = 30;
  localparam int PRES  = 120;

  logic        clk;
  logic        global_reset;
  logic        m_low;
  logic [55:0] rom_id;
  logic [7:0]  crc_in;
  logic        busy;
  logic [7:0]  cmd_byte;
  logic        rom_sent;
  wire         dsn_io;

  assign dsn_io = m_low ? 1'b0 : 1'bz;
  pullup (dsn_io);

  dsn_slave #(
    .MXCNT      (16),
    .CNT_RST    (480),
    .CNT_SAMPLE (30),
    .CNT_PWAIT  (PWAIT),
    .CNT_PRES   (PRES),
    .CNT_RD0    (30)
  ) dut (
    .clock        (clk),
    .global_reset (global_reset),
    .dsn_io       (dsn_io),
    .rom_id       (rom_id),
    .crc_in       (crc_in),
    .busy         (busy),
    .cmd_byte     (cmd_byte),
    .rom_sent     (rom_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int drv_cnt = 0;
  int rs_cnt  = 0;

  // Slave pull-downs (line low while the master is not pulling) and
  // rom_sent pulses, counted monotonically.
  always @(negedge clk) begin
    if (!m_low && dsn_io === 1'b0) drv_cnt++;
    if (rom_sent === 1'b1) rs_cnt++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bus reset, then measure the presence pulse relative to the release.
  task automatic reset_pulse(output int st, output int wd);
    m_low = 1'b1;
    tick(600);
    m_low = 1'b0;
    st = -1;
    wd = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (dsn_io === 1'b0) begin
        if (st < 0) st = i + 1;
        wd++;
      end
    end
  endtask

  task automatic write_bit(input logic b);
    m_low = 1'b1;
    tick(b ? 4 : 100);
    m_low = 1'b0;
    tick(b ? 126 : 30);
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b1;
    tick(2);
    m_low = 1'b0;
    tick(6);
    b = (dsn_io !== 1'b0);
    tick(52);
  endtask

  task automatic read_bits(input int n, output logic [63:0] v);
    logic b;
    v = '1;
    for (int i = 0; i < n; i++) begin
      read_bit(b);
      v[i] = b;
    end
  endtask

  task automatic check_presence(input string tag);
    int st;
    int wd;
    reset_pulse(st, wd);
    chk({tag, "_start"}, 64'((st >= PWAIT + 1) && (st <= PWAIT + 5)), 64'd1);
    chk({tag, "_width"}, 64'(wd), 64'(PRES));
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
  endtask

  initial begin
    logic [63:0] exp_rom;
    logic [63:0] rd;
    logic [7:0]  exp_crc;
    int          d0;
    int          r0;

    global_reset = 1'b1;
    m_low        = 1'b0;
    rom_id       = 56'h00_0001B81C_02;
    crc_in       = 8'h5A;
`ifdef DSN_SLAVE_CRC_EN
    exp_crc = 8'hA2;
`else
    exp_crc = 8'h5A;
`endif
    exp_rom = {exp_crc, rom_id};

    // Reset state
    tick(5);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_cmd", {56'd0, cmd_byte}, 64'd0);
    chk("rst_rom_sent", {63'd0, rom_sent}, 64'd0);
    chk("rst_line", {63'd0, dsn_io === 1'b1}, 64'd1);
    global_reset = 1'b0;
    tick(20);

    // Presence after a bus reset, then Read ROM
    check_presence("pres1");
    r0 = rs_cnt;
    write_byte(8'h33);
    chk("cmd_33", {56'd0, cmd_byte}, 64'h33);
    read_bits(64, rd);
    chk("rom_full", rd, exp_rom);
    chk("rom_crc", {56'd0, rd[63:56]}, {56'd0, exp_crc});
    chk("rom_sent_once", 64'(rs_cnt - r0), 64'd1);
    chk("done_busy", {63'd0, busy}, 64'd1);

    // Non-ROM command: quiet until the next reset
    check_presence("pres2");
    write_byte(8'hCC);
    chk("cmd_cc", {56'd0, cmd_byte}, 64'hCC);
    d0 = drv_cnt;
    r0 = rs_cnt;
    read_bits(64, rd);
    chk("cc_no_drive", 64'(drv_cnt - d0), 64'd0);
    chk("cc_read_ones", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("cc_no_rom_sent", 64'(rs_cnt - r0), 64'd0);

    // Bus reset in the middle of a ROM read restarts at bit 0
    check_presence("pres3");
    write_byte(8'h33);
    read_bits(21, rd);
    chk("rom_part", 64'(rd[20:0]), 64'(exp_rom[20:0]));
    check_presence("pres_mid");
    r0 = rs_cnt;
    write_byte(8'h33);
    chk("cmd_33_again", {56'd0, cmd_byte}, 64'h33);
    read_bits(64, rd);
    chk("rom_restart", rd, exp_rom);
    chk("rom_sent_restart", 64'(rs_cnt - r0), 64'd1);

    // global_reset during the presence pulse
    m_low = 1'b1;
    tick(600);
    m_low = 1'b0;
    tick(60);
    chk("pres_active", {63'd0, dsn_io === 1'b0}, 64'd1);
    global_reset = 1'b1;
    tick(1);
    chk("grst_line", {63'd0, dsn_io === 1'b1}, 64'd1);
    chk("grst_busy", {63'd0, busy}, 64'd0);
    chk("grst_cmd", {56'd0, cmd_byte}, 64'd0);
    global_reset = 1'b0;
    tick(200);
    chk("grst_stay_idle", {63'd0, busy}, 64'd0);
    chk("grst_stay_line", {63'd0, dsn_io === 1'b1}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
